// File: rtl/sram_controller_if.sv
// sram_controller_if: MEM-stage load/store handshake between the pipeline and the SRAM controller.
interface sram_controller_if;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [31:0] rdata;
    logic        ready;
    modport master (output mem_r_en, mem_w_en, alu_res, st_val, input rdata, ready);
    modport slave  (input mem_r_en, mem_w_en, alu_res, st_val, output rdata, ready);
endinterface

// File: rtl/sram_controller.sv
// sram_controller: sequences MEM-stage loads/stores onto a 64-bit SRAM with wait states and RMW stores.
// Optional SRAM_WBUF_EN: one-entry posted store buffer; a store is accepted in IDLE without stalling.
module sram_controller #(
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    sram_controller_if.slave   mem_if,
    inout  wire  [63:0]        sram_dq_io,
    output logic [16:0]        sram_addr_o,
    output logic               sram_we_n_o
);
    localparam int CW = $clog2(WAIT_CYCLES);
    typedef enum logic [2:0] {IDLE, RD, WR_RD, WR, DONE} state_t;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [16:0]   addr_q;
    logic          h_q;
    logic          we_n_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic [63:0]   line_q;
    logic [31:0]   off;
    logic          last;
    logic          unused_off;
    assign off         = mem_if.alu_res - 32'(BASE_ADDR);
    assign unused_off  = ^{off[31:20], off[1:0]};
    assign last        = cnt_q == CW'(WAIT_CYCLES - 1);
    assign sram_addr_o = addr_q;
    assign sram_we_n_o = we_n_q;
    assign sram_dq_io  = we_n_q ? 64'bz : line_q;
    assign mem_if.rdata = rdata_q;
`ifdef SRAM_WBUF_EN
    assign mem_if.ready = (state_q == IDLE && (mem_if.mem_w_en || !mem_if.mem_r_en)) || state_q == DONE;
`else
    assign mem_if.ready = (state_q == IDLE && !(mem_if.mem_w_en || mem_if.mem_r_en)) || state_q == DONE;
`endif
    // Access FSM: latches the request in IDLE, counts wait states, captures/merges data and drives the strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            h_q     <= 1'b0;
            we_n_q  <= 1'b1;
            wdata_q <= '0;
            rdata_q <= '0;
            line_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (mem_if.mem_w_en || mem_if.mem_r_en) begin
                        addr_q  <= off[19:3];
                        h_q     <= off[2];
                        state_q <= mem_if.mem_w_en ? WR_RD : RD;
                    end
                    if (mem_if.mem_w_en)
                        wdata_q <= mem_if.st_val;
                end
                RD: begin
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        rdata_q <= h_q ? sram_dq_io[63:32] : sram_dq_io[31:0];
                        state_q <= DONE;
                    end
                end
                WR_RD: begin
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        line_q  <= h_q ? {wdata_q, sram_dq_io[31:0]} : {sram_dq_io[63:32], wdata_q};
                        we_n_q  <= 1'b0;
                        state_q <= WR;
                    end
                end
                WR: begin
                    cnt_q <= last ? '0 : cnt_q + 1'b1;
                    if (last) begin
                        we_n_q  <= 1'b1;
`ifdef SRAM_WBUF_EN
                        state_q <= IDLE;
`else
                        state_q <= DONE;
`endif
                    end
                end
                DONE: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed checks of the SRAM controller against a small behavioural SRAM.
module tb_sram_controller;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic model_en = 1'b0;
    int total = 0;
    int passed = 0;
    wire  [63:0] sram_dq;
    logic [16:0] sram_addr;
    logic        sram_we_n;
    logic [63:0] sram_mem [16];
    sram_controller_if bus();
    sram_controller #(.WAIT_CYCLES(4), .BASE_ADDR(1024)) dut (
        .clk(clk),
        .rst(rst),
        .mem_if(bus),
        .sram_dq_io(sram_dq),
        .sram_addr_o(sram_addr),
        .sram_we_n_o(sram_we_n)
    );
    always #5 clk = ~clk;
    assign sram_dq = (model_en && sram_we_n) ? sram_mem[sram_addr[3:0]] : 64'bz;
    always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr[3:0]] <= sram_dq;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int low, output int wel, output logic [31:0] rd);
        @(negedge clk);
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.alu_res  = a;
        bus.st_val   = d;
        low = 0;
        wel = 0;
        #1;
        while (!bus.ready && low < 50) begin
            low++;
            if (!sram_we_n) wel++;
            @(negedge clk);
            #1;
        end
        rd = bus.rdata;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        int low;
        int wel;
        logic [31:0] rd;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.alu_res  = '0;
        bus.st_val   = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_we_n", 64'(sram_we_n), 64'd1);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_rdata", 64'(bus.rdata), 64'd0);
        total++;
        assert (sram_dq === 64'bz) passed++;
        else $error("FAIL rst_dq: observed %h expected z", sram_dq);
        rst = 1'b1;
        model_en = 1'b1;
        @(negedge clk);
        chk("idle_ready", 64'(bus.ready), 64'd1);
`ifdef SRAM_WBUF_EN
        @(negedge clk);
        bus.mem_w_en = 1'b1;
        bus.alu_res  = 32'd1048;
        bus.st_val   = 32'hAAAA5555;
        #1;
        chk("wb_first_ready", 64'(bus.ready), 64'd1);
        @(negedge clk);
        bus.alu_res = 32'd1052;
        bus.st_val  = 32'hBBBB6666;
        low = 0;
        #1;
        while (!bus.ready && low < 50) begin
            low++;
            @(negedge clk);
            #1;
        end
        chk("wb_second_low", 64'(low), 64'd8);
        @(posedge clk);
        #1;
        bus.mem_w_en = 1'b0;
        access(1'b1, 1'b0, 32'd1048, 32'd0, low, wel, rd);
        chk("wb_ld_first", 64'(rd), 64'hAAAA5555);
        access(1'b1, 1'b0, 32'd1052, 32'd0, low, wel, rd);
        chk("wb_ld_second", 64'(rd), 64'hBBBB6666);
        chk("wb_line3", sram_mem[3], 64'hBBBB6666_AAAA5555);
`else
        access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, low, wel, rd);
        chk("st1_low", 64'(low), 64'd9);
        chk("st1_we_low", 64'(wel), 64'd4);
        chk("st1_addr", 64'(sram_addr), 64'd1);
        access(1'b1, 1'b0, 32'd1032, 32'd0, low, wel, rd);
        chk("ld1_low", 64'(low), 64'd5);
        chk("ld1_rdata", 64'(rd), 64'hDEADBEEF);
        access(1'b0, 1'b1, 32'd1024, 32'h11111111, low, wel, rd);
        access(1'b0, 1'b1, 32'd1028, 32'h22222222, low, wel, rd);
        chk("line0", sram_mem[0], 64'h22222222_11111111);
        chk("st_keeps_rdata", 64'(bus.rdata), 64'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1024, 32'd0, low, wel, rd);
        chk("ld_lo_half", 64'(rd), 64'h11111111);
        access(1'b1, 1'b0, 32'd1028, 32'd0, low, wel, rd);
        chk("ld_hi_half", 64'(rd), 64'h22222222);
        access(1'b1, 1'b1, 32'd1040, 32'h5, low, wel, rd);
        chk("rw_as_write_low", 64'(low), 64'd9);
        chk("rw_keeps_rdata", 64'(bus.rdata), 64'h22222222);
        access(1'b1, 1'b0, 32'd1040, 32'd0, low, wel, rd);
        chk("rw_readback", 64'(rd), 64'h5);
        access(1'b1, 1'b0, 32'd1032 + 32'h0010_0000, 32'd0, low, wel, rd);
        chk("wrap_rdata", 64'(rd), 64'hDEADBEEF);
        chk("wrap_addr", 64'(sram_addr), 64'd1);
        access(1'b1, 1'b0, 32'd1035, 32'd0, low, wel, rd);
        chk("lowbits_rdata", 64'(rd), 64'hDEADBEEF);
`endif
        @(negedge clk);
        bus.mem_w_en = 1'b1;
        bus.alu_res  = 32'd1064;
        bus.st_val   = 32'h12345678;
        @(posedge clk);
        #1;
        bus.mem_w_en = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("wr2_we_low", 64'(sram_we_n), 64'd0);
        model_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("abort_we_n", 64'(sram_we_n), 64'd1);
        total++;
        assert (sram_dq === 64'bz) passed++;
        else $error("FAIL abort_dq: observed %h expected z", sram_dq);
        chk("abort_ready", 64'(bus.ready), 64'd1);
        chk("abort_addr", 64'(sram_addr), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_retry_we_n", 64'(sram_we_n), 64'd1);
        chk("no_retry_ready", 64'(bus.ready), 64'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
# sram_controller

Sequences every data-memory access from the MEM stage onto the shared 64-bit off-chip SRAM (17-bit word address, active-low write strobe, bidirectional DQ, clocked at half the core rate). It maps 32-bit ARM byte addresses onto 64-bit SRAM lines, inserts wait states, performs read-modify-write for 32-bit stores, and drives `ready` low to freeze the pipeline until the access completes.

## Interface
- `WAIT_CYCLES`, 4: core `clk` cycles each SRAM phase (address/strobe/data) is held; minimum 2.
- `BASE_ADDR`, 1024: byte address mapped to SRAM line 0.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_R_EN`  in  1  load request; held by the pipeline until `ready`=1.
- `MEM_W_EN`  in  1  store request; held until `ready`=1.
- `ALU_Res`  in  32  byte address.
- `ST_Val`  in  32  store data.
- `rdata`  out  32  load data, valid in the cycle `ready` returns high.
- `ready`  out  1  0 = freeze pipeline.
- `SRAM_DQ`  inout  64  SRAM data; driven only in WR, else high-Z.
- `SRAM_ADDR`  out  17  SRAM line address.
- `SRAM_WE_N`  out  1  SRAM write strobe, active low.

## Operation
- Address map: `off = ALU_Res - BASE_ADDR`; `SRAM_ADDR = off[19:3]`; half select `h = off[2]` (h=0 → DQ[31:0], h=1 → DQ[63:32]); `off[1:0]` ignored; bits above 19 ignored (wrap).
- States: IDLE, RD, WR_RD, WR, DONE.
- IDLE: if `MEM_W_EN` → latch address, h, `ST_Val`; go WR_RD. Else if `MEM_R_EN` → latch address, h; go RD. Both asserted → treated as write.
- RD: hold `SRAM_ADDR`, `SRAM_WE_N`=1 for WAIT_CYCLES cycles; on last cycle's edge capture selected half of `SRAM_DQ` into `rdata`; go DONE.
- WR_RD: as RD, but capture full 64-bit line into merge register; replace half h with latched store data; go WR.
- WR: drive merged line on `SRAM_DQ`, `SRAM_WE_N`=0 for WAIT_CYCLES cycles; on exit release DQ and raise `SRAM_WE_N` on the same edge; go DONE.
- DONE: one cycle, `ready`=1; go IDLE unconditionally (the held request is not re-launched).
- `ready` = (IDLE and no request) or DONE; combinational so it drops in the same cycle a request appears.
- Wait counter: 0..WAIT_CYCLES-1, cleared on every state change.

## Timing
- Reset (async, `rst`=0): state IDLE, `ready`=1, `rdata`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, counter 0, merge register 0. Reset mid-access aborts immediately; a WR aborted mid-strobe is not retried.
- Request seen in cycle 0. Load: `ready` low cycles 0..WAIT_CYCLES, high in cycle WAIT_CYCLES+1 with `rdata` valid.
- Store: `ready` low cycles 0..2·WAIT_CYCLES, high in cycle 2·WAIT_CYCLES+1.
- `SRAM_ADDR` stable from cycle 1 until leaving RD/WR; changes only on state entry from IDLE.
- `rdata` holds last load value until next load completes; stores do not alter it.
- Back-to-back requests: next access launches in the IDLE cycle following DONE; no extra bubble.

## Configuration
- `SRAM_WBUF_EN` defined: one-entry posted store buffer. A store seen in IDLE keeps `ready`=1 that cycle (pipeline advances), buffer captures address/data, controller runs WR_RD→WR then returns directly to IDLE (no DONE). Any request arriving while state ≠ IDLE sees `ready`=0 until the buffer drains, then is processed normally from IDLE.
- Not defined: stores stall as in Operation; no buffer logic present.

## Test plan
- Reset then idle, no requests → `ready`=1, `SRAM_WE_N`=1, `SRAM_DQ`=Z, `SRAM_ADDR`=0.
- Store 0xDEADBEEF @1032, then load @1032 (WAIT_CYCLES=4) → store `ready` low 9 cycles, `SRAM_ADDR`=1, WE_N low 4 cycles; load `ready` low 5 cycles, `rdata`=0xDEADBEEF.
- Store 0x11111111 @1024, 0x22222222 @1028, load both → line 0 = 0x22222222_11111111; loads return each value (RMW preserves other half).
- `MEM_R_EN`=`MEM_W_EN`=1 @1040, `ST_Val`=0x5 → write performed; later load @1040 returns 0x5.
- Assert `rst`=0 during WR cycle 2 → WE_N=1 and DQ=Z within same time step, state IDLE, `ready`=1.
- With `SRAM_WBUF_EN`: two consecutive stores → first accepted with `ready`=1, second sees `ready`=0 for 8 cycles, then its own 8-cycle drain proceeds; both values read back correctly.
